// File: rtl/game_pkg.sv
// Shared types and constants for the road-crossing game: FSM state encoding,
// screen/sprite geometry and default phase lengths.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_e;

    localparam int H_DISPLAY     = 32'd640;
    localparam int V_DISPLAY     = 32'd480;
    localparam int PLAYER_WIDTH  = 32'd16;
    localparam int PLAYER_HEIGHT = 32'd16;
    localparam int CAR_WIDTH     = 32'd32;
    localparam int CAR_HEIGHT    = 32'd16;
    localparam int LANE0_Y       = 32'd96;
    localparam int LANE1_Y       = 32'd160;
    localparam int LANE2_Y       = 32'd224;
    localparam int LANE3_Y       = 32'd288;
    localparam int LANE4_Y       = 32'd352;

    localparam int DEF_LIVES           = 32'd4;
    localparam int DEF_HIT_FRAMES      = 32'd60;
    localparam int DEF_LEVEL_FRAMES    = 32'd90;
    localparam int DEF_GO_FRAMES       = 32'd120;
    localparam int DEF_LEVEL_EVERY     = 32'd5;
    localparam int DEF_MAX_LEVEL       = 32'd7;
    localparam int DEF_CAR_PERIOD_BASE = 32'd400000;
    localparam int DEF_CAR_PERIOD_STEP = 32'd50000;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the player/collision datapath (master) and the game-flow
// sequencer (slave), including the display-facing status outputs.
interface game_sequencer_if #(
    parameter int LIVES = 32'd4
);
    logic             frame_tick;
    logic [3:0]       btn;
    logic             collision;
    logic             crossed;
    logic             move_en;
    logic             respawn;
    logic [LIVES-1:0] life_leds;
    logic [3:0]       score_tens;
    logic [3:0]       score_units;
    logic [2:0]       level;
    logic [31:0]      car_period;
    logic [2:0]       state;

    modport master (
        output frame_tick, btn, collision, crossed,
        input  move_en, respawn, life_leds, score_tens, score_units,
               level, car_period, state
    );

    modport slave (
        input  frame_tick, btn, collision, crossed,
        output move_en, respawn, life_leds, score_tens, score_units,
               level, car_period, state
    );
endinterface

// File: rtl/game_sequencer_bcd_counter2.sv
// Two-digit BCD counter that increments on request, saturates at 99 and
// clears synchronously; clear wins over increment.
module bcd_counter2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       at_max_s;

    assign at_max_s = (tens_q == 4'd9) && (units_q == 4'd9);

    // Next-digit computation with units-to-tens carry.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_i) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc_i && !at_max_s) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else begin
            tens_d  = tens_q;
            units_d = units_q;
        end
    end

    // Digit registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller for the road-crossing game: sequences attract, play,
// hit recovery, level-up and game-over, and owns lives, score and level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES           = DEF_LIVES,
    parameter int HIT_FRAMES      = DEF_HIT_FRAMES,
    parameter int LEVEL_FRAMES    = DEF_LEVEL_FRAMES,
    parameter int GO_FRAMES       = DEF_GO_FRAMES,
    parameter int LEVEL_EVERY     = DEF_LEVEL_EVERY,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
    parameter int CAR_PERIOD_BASE = DEF_CAR_PERIOD_BASE,
    parameter int CAR_PERIOD_STEP = DEF_CAR_PERIOD_STEP
) (
    input logic             CLK,
    input logic             RST_N,
    game_sequencer_if.slave bus
);

    localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  LEVEL_LAST = 8'(LEVEL_FRAMES - 1);
    localparam logic [7:0]  GO_LAST    = 8'(GO_FRAMES - 1);
    localparam logic [7:0]  CROSS_LAST = 8'(LEVEL_EVERY - 1);
    localparam logic [2:0]  MAX_LVL    = 3'(MAX_LEVEL);
    localparam logic [31:0] BASE32     = 32'(CAR_PERIOD_BASE);
    localparam logic [31:0] STEP32     = 32'(CAR_PERIOD_STEP);

    game_state_e      state_q;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       cross_cnt_q;
    logic [LIVES-1:0] life_q;
    logic [2:0]       level_q;
    logic [31:0]      car_period_q, car_period_d;
    logic             move_en_q;
    logic             respawn_q;
    logic             go_ready_q;
    logic             arm_q;
    logic [3:0]       btn_prev_q;

    logic [3:0]       btn_rise_s;
    logic             combo_s;
    logic             start_s;
    logic             score_inc_s;
    logic [31:0]      level_cost_s;

    // Button edges; the first cycle after reset only primes btn_prev_q so a
    // button held through reset needs a release before it counts.
    always_comb begin
        btn_rise_s = 4'd0;
        combo_s    = 1'b0;
        if (arm_q) begin
            btn_rise_s = bus.btn & ~btn_prev_q;
            combo_s    = (&bus.btn) & ~(&btn_prev_q);
        end else begin
            btn_rise_s = 4'd0;
            combo_s    = 1'b0;
        end
    end

    // New-game request: restart combo anywhere, or a press from attract/game-over.
    always_comb begin
        start_s = 1'b0;
        if (combo_s) begin
            start_s = 1'b1;
        end else if ((|btn_rise_s) && (state_q == ST_IDLE)) begin
            start_s = 1'b1;
        end else if ((|btn_rise_s) && (state_q == ST_GAME_OVER) && go_ready_q) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    assign score_inc_s = (state_q == ST_PLAY) && bus.crossed && !bus.collision && !combo_s;

    // Car step period from the current level, clamped so it can never wrap.
    always_comb begin
        level_cost_s = {29'd0, level_q} * STEP32;
        if (level_cost_s < BASE32) begin
            car_period_d = BASE32 - level_cost_s;
        end else begin
            car_period_d = 32'd1;
        end
    end

    // Game-flow FSM with lives, level, crossing and frame counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 8'd0;
            cross_cnt_q  <= 8'd0;
            life_q       <= '1;
            level_q      <= 3'd0;
            car_period_q <= BASE32;
            move_en_q    <= 1'b0;
            respawn_q    <= 1'b0;
            go_ready_q   <= 1'b0;
            arm_q        <= 1'b0;
            btn_prev_q   <= 4'd0;
        end else begin
            btn_prev_q   <= bus.btn;
            arm_q        <= 1'b1;
            respawn_q    <= 1'b0;
            car_period_q <= car_period_d;
            if (start_s) begin
                state_q     <= ST_PLAY;
                move_en_q   <= 1'b1;
                respawn_q   <= 1'b1;
                frame_cnt_q <= 8'd0;
                cross_cnt_q <= 8'd0;
                life_q      <= '1;
                level_q     <= 3'd0;
                go_ready_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        move_en_q <= 1'b0;
                    end
                    ST_PLAY: begin
                        if (bus.collision) begin
                            move_en_q   <= 1'b0;
                            frame_cnt_q <= 8'd0;
                            if (life_q[LIVES-2]) begin
                                life_q    <= {life_q[LIVES-2:0], 1'b0};
                                state_q   <= ST_HIT;
                                respawn_q <= 1'b1;
                            end else begin
                                life_q     <= '0;
                                state_q    <= ST_GAME_OVER;
                                go_ready_q <= 1'b0;
                            end
                        end else if (bus.crossed) begin
                            respawn_q <= 1'b1;
                            if (cross_cnt_q == CROSS_LAST) begin
                                cross_cnt_q <= 8'd0;
                                state_q     <= ST_LEVEL_UP;
                                move_en_q   <= 1'b0;
                                frame_cnt_q <= 8'd0;
                                if (level_q < MAX_LVL) begin
                                    level_q <= level_q + 3'd1;
                                end
                            end else begin
                                cross_cnt_q <= cross_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_HIT: begin
                        if (bus.frame_tick) begin
                            if (frame_cnt_q == HIT_LAST) begin
                                state_q     <= ST_PLAY;
                                move_en_q   <= 1'b1;
                                frame_cnt_q <= 8'd0;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_LEVEL_UP: begin
                        if (bus.frame_tick) begin
                            if (frame_cnt_q == LEVEL_LAST) begin
                                state_q     <= ST_PLAY;
                                move_en_q   <= 1'b1;
                                frame_cnt_q <= 8'd0;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_GAME_OVER: begin
                        // Counter stops once the restart window has opened.
                        if (bus.frame_tick && !go_ready_q) begin
                            if (frame_cnt_q == GO_LAST) begin
                                go_ready_q <= 1'b1;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        move_en_q   <= 1'b0;
                        frame_cnt_q <= 8'd0;
                    end
                endcase
            end
        end
    end

    bcd_counter2 u_score (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .clr_i   (start_s),
        .inc_i   (score_inc_s),
        .tens_o  (bus.score_tens),
        .units_o (bus.score_units)
    );

    assign bus.move_en    = move_en_q;
    assign bus.respawn    = respawn_q;
    assign bus.life_leds  = life_q;
    assign bus.level      = level_q;
    assign bus.car_period = car_period_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: vector table, directed multi-cycle
// scenarios and a randomized run against a count-based reference model.
module tb_game_sequencer;

    localparam int LIVES        = 4;
    localparam int HIT_FRAMES   = 60;
    localparam int LEVEL_FRAMES = 90;
    localparam int GO_FRAMES    = 120;
    localparam int LEVEL_EVERY  = 5;
    localparam int MAX_LEVEL    = 7;
    localparam int BASE         = 400000;
    localparam int STEP         = 50000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    game_sequencer_if #(.LIVES(LIVES)) gif ();

    game_sequencer dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (gif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: game quantities held as plain integers.
    int         m_st, m_lives, m_score, m_level, m_cross, m_ticks, m_period;
    logic [3:0] m_prev;
    bit         m_first, m_rsp;

    function automatic logic [3:0] thermo(input int n);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 0; i < n; i++) t[LIVES-1-i] = 1'b1;
        return t;
    endfunction

    task automatic new_game();
        m_st = 1; m_lives = LIVES; m_score = 0; m_level = 0;
        m_cross = 0; m_ticks = 0; m_rsp = 1'b1;
    endtask

    task automatic model_reset();
        m_st = 0; m_lives = LIVES; m_score = 0; m_level = 0; m_cross = 0;
        m_ticks = 0; m_period = BASE; m_prev = 4'd0; m_first = 1'b1; m_rsp = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic ft, input logic col, input logic cr);
        int         old_level;
        logic [3:0] rise;
        bit         combo;
        old_level = m_level;
        rise  = m_first ? 4'd0 : (b & ~m_prev);
        combo = !m_first && (b == 4'hF) && (m_prev != 4'hF);
        m_prev = b; m_first = 1'b0; m_rsp = 1'b0;
        if (combo) new_game();
        else begin
            case (m_st)
                0: if (rise != 4'd0) new_game();
                1: begin
                    if (col) begin
                        m_ticks = 0;
                        if (m_lives > 1) begin m_lives--; m_st = 2; m_rsp = 1'b1; end
                        else begin m_lives = 0; m_st = 4; end
                    end else if (cr) begin
                        m_score = (m_score < 99) ? m_score + 1 : 99;
                        m_rsp = 1'b1;
                        m_cross++;
                        if (m_cross == LEVEL_EVERY) begin
                            m_cross = 0; m_st = 3; m_ticks = 0;
                            if (m_level < MAX_LEVEL) m_level++;
                        end
                    end
                end
                2: if (ft) begin m_ticks++; if (m_ticks == HIT_FRAMES) m_st = 1; end
                3: if (ft) begin m_ticks++; if (m_ticks == LEVEL_FRAMES) m_st = 1; end
                4: begin
                    if (m_ticks >= GO_FRAMES && rise != 4'd0) new_game();
                    else if (ft) m_ticks++;
                end
                default: m_st = 0;
            endcase
        end
        m_period = BASE - old_level * STEP;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string name);
        logic [51:0] act, exp;
        act = {gif.state, gif.move_en, gif.respawn, gif.life_leds, gif.score_tens,
               gif.score_units, gif.level, gif.car_period};
        exp = {3'(m_st), (m_st == 1), m_rsp, thermo(m_lives), 4'(m_score / 10),
               4'(m_score % 10), 3'(m_level), 32'(m_period)};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d mv=%0b rsp=%0b leds=%b score=%0h%0h lvl=%0d per=%0d expected st=%0d mv=%0b rsp=%0b leds=%b score=%0d lvl=%0d per=%0d at %0t",
                     name, gif.state, gif.move_en, gif.respawn, gif.life_leds, gif.score_tens,
                     gif.score_units, gif.level, gif.car_period, m_st, (m_st == 1), m_rsp,
                     thermo(m_lives), m_score, m_level, m_period, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] b, input logic ft, input logic col, input logic cr);
        gif.btn = b; gif.frame_tick = ft; gif.collision = col; gif.crossed = cr;
        @(posedge clk);
        model_step(b, ft, col, cr);
        #1;
        chk_outputs("cycle");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [3:0] b);
        gif.btn = b; gif.frame_tick = 1'b0; gif.collision = 1'b0; gif.crossed = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       ft, col, cr;
        int         st;
        logic [3:0] leds;
        int         score;
        logic       rsp;
    } vec_t;

    vec_t vecs[9];
    int   rsp_cnt;

    initial begin
        n_tests = 0; n_fail = 0; rsp_cnt = 0;
        rst_n = 1'b0;
        vecs[0] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 4'hF, 0, 1'b0};
        vecs[1] = '{4'h1, 1'b0, 1'b0, 1'b0, 1, 4'hF, 0, 1'b1};
        vecs[2] = '{4'h1, 1'b0, 1'b0, 1'b0, 1, 4'hF, 0, 1'b0};
        vecs[3] = '{4'h0, 1'b0, 1'b0, 1'b1, 1, 4'hF, 1, 1'b1};
        vecs[4] = '{4'h0, 1'b0, 1'b0, 1'b1, 1, 4'hF, 2, 1'b1};
        vecs[5] = '{4'h0, 1'b0, 1'b0, 1'b0, 1, 4'hF, 2, 1'b0};
        vecs[6] = '{4'h0, 1'b0, 1'b1, 1'b0, 2, 4'hE, 2, 1'b1};
        vecs[7] = '{4'h0, 1'b0, 1'b1, 1'b0, 2, 4'hE, 2, 1'b0};
        vecs[8] = '{4'h0, 1'b0, 1'b0, 1'b1, 2, 4'hE, 2, 1'b0};

        // Button held through reset must not start a game.
        do_reset(4'h1);
        chk("reset_leds", gif.life_leds, 4'hF);
        repeat (3) cyc(4'h1, 1'b0, 1'b0, 1'b0);
        chk("held_no_start", gif.state, 0);
        repeat (2) cyc(4'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].btn, vecs[i].ft, vecs[i].col, vecs[i].cr);
            chk($sformatf("vec%0d", i),
                {gif.state, gif.life_leds, gif.score_tens, gif.score_units, gif.respawn},
                {3'(vecs[i].st), vecs[i].leds, 4'(vecs[i].score / 10), 4'(vecs[i].score % 10), vecs[i].rsp});
        end

        // Hit recovery: collision held and ignored through 59 ticks, exit on 60th.
        for (int i = 0; i < 59; i++) cyc(4'h0, 1'b1, 1'b1, 1'b0);
        chk("hit_59_state", gif.state, 2);
        chk("hit_59_leds", gif.life_leds, 4'hE);
        cyc(4'h0, 1'b1, 1'b1, 1'b0);
        chk("hit_60_state", gif.state, 1);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);

        // Restart combo, then first level-up.
        cyc(4'hF, 1'b0, 1'b0, 1'b0);
        chk("combo_rsp", gif.respawn, 1);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'h0, 1'b0, 1'b0, 1'b1);
        chk("lvl_score", {gif.score_tens, gif.score_units}, 8'h05);
        chk("lvl_level", gif.level, 1);
        chk("lvl_state", gif.state, 3);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("lvl_period", gif.car_period, 350000);
        ticks(89);
        chk("lvl_89", gif.state, 3);
        ticks(1);
        chk("lvl_90", gif.state, 1);

        // Collision and crossing together at score 09.
        for (int i = 0; i < 4; i++) cyc(4'h0, 1'b0, 1'b0, 1'b1);
        chk("score_09", {gif.score_tens, gif.score_units}, 8'h09);
        cyc(4'h0, 1'b0, 1'b1, 1'b1);
        chk("both_score", {gif.score_tens, gif.score_units}, 8'h09);
        chk("both_state", gif.state, 2);
        chk("both_leds", gif.life_leds, 4'hE);
        ticks(HIT_FRAMES);

        // Remaining lives to game over; restart window timing.
        for (int i = 0; i < 3; i++) begin
            cyc(4'h0, 1'b0, 1'b1, 1'b0);
            if (i < 2) ticks(HIT_FRAMES);
        end
        chk("go_state", gif.state, 4);
        chk("go_leds", gif.life_leds, 4'h0);
        chk("go_score_held", {gif.score_tens, gif.score_units}, 8'h09);
        ticks(50);
        cyc(4'h1, 1'b0, 1'b0, 1'b0);
        chk("go_early_press", gif.state, 4);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        ticks(70);
        cyc(4'h2, 1'b0, 1'b0, 1'b0);
        chk("go_restart_state", gif.state, 1);
        chk("go_restart_leds", gif.life_leds, 4'hF);
        chk("go_restart_score", {gif.score_tens, gif.score_units}, 8'h00);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);

        // Held combo in game over restarts exactly once.
        for (int i = 0; i < 4; i++) begin
            cyc(4'h0, 1'b0, 1'b1, 1'b0);
            if (i < 3) ticks(HIT_FRAMES);
        end
        ticks(3);
        for (int i = 0; i < 5; i++) begin
            cyc(4'hF, 1'b0, 1'b0, 1'b0);
            if (i == 0) chk("combo_go_state", gif.state, 1);
            rsp_cnt += int'(gif.respawn);
        end
        chk("combo_single_rsp", rsp_cnt, 1);
        chk("combo_leds", gif.life_leds, 4'hF);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);

        // Long run to score and level saturation.
        for (int i = 0; i < 105; i++) begin
            cyc(4'h0, 1'b0, 1'b0, 1'b1);
            if (m_st == 3) ticks(LEVEL_FRAMES);
        end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_score", {gif.score_tens, gif.score_units}, 8'h99);
        chk("sat_level", gif.level, 7);
        chk("sat_period", gif.car_period, 50000);

        // Randomized traffic, with one mid-run reset.
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                do_reset(4'($urandom_range(0, 15)));
            end
            cyc(4'hF, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3000; i++) begin
                logic [3:0] b;
                b = 4'd0;
                if ($urandom_range(0, 39) == 0) b = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 299) == 0) b = 4'hF;
                cyc(b, ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 14) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
